// File: rtl/jk_pkg.sv
// Shared JK flip-flop definitions: command encoding and the excitation function
// that maps a (present, next) bit pair back to the J/K drive producing it.
package jk_pkg;

    typedef enum logic [1:0] {
        JK_HOLD = 2'b00,
        JK_CLR  = 2'b01,
        JK_SET  = 2'b10,
        JK_TOG  = 2'b11
    } jk_cmd_t;

    // Don't-care entries of the excitation table resolve to 0, so toggle is never produced.
    function automatic jk_cmd_t jk_excite(input logic q, input logic q_next);
        case ({q, q_next})
            2'b01:   return JK_SET;
            2'b10:   return JK_CLR;
            default: return JK_HOLD;
        endcase
    endfunction

endpackage

// File: rtl/jk_cell.sv
// Single JK flip-flop with synchronous active-high reset.
module jk_cell
    import jk_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic j,
    input  logic k,
    output logic q
);

    // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            case (jk_cmd_t'({j, k}))
                JK_HOLD: q <= q;
                JK_CLR:  q <= 1'b0;
                JK_SET:  q <= 1'b1;
                JK_TOG:  q <= ~q;
                default: q <= q;
            endcase
        end
    end

endmodule

// File: rtl/jk_mod_counter.sv
// Mod-N up/down counter built from JK cells; next count is converted to J/K drive.
// Optional registered Gray-code output when JK_MOD_COUNTER_GRAY_EN is defined.
module jk_mod_counter
    import jk_pkg::*;
#(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] j_vec,
    output logic [WIDTH-1:0] k_vec,
    output logic             tc,
    output logic             load_err
`ifdef JK_MOD_COUNTER_GRAY_EN
    ,
    output logic [WIDTH-1:0] q_gray
`endif
);

    localparam logic [WIDTH-1:0] MAX_COUNT = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH:0]   MOD_EXT   = (WIDTH + 1)'(MODULUS);

    logic [WIDTH-1:0] target;
    logic             load_bad;
    logic             at_max;
    logic             at_zero;

    assign load_bad = ({1'b0, load_val} >= MOD_EXT);
    assign at_max   = (q == MAX_COUNT);
    assign at_zero  = (q == '0);

    // NOTE: target gets a default first so no path through the block leaves it unassigned (no latch).
    always_comb begin
        target = q;
        if (load) begin
            target = load_bad ? '0 : load_val;
        end else if (en) begin
            if (up) begin
                target = at_max ? '0 : q + 1'b1;
            end else begin
                target = at_zero ? MAX_COUNT : q - 1'b1;
            end
        end
    end

    assign tc = en & ~load & ((up & at_max) | (~up & at_zero));

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign {j_vec[i], k_vec[i]} = jk_excite(q[i], target[i]);

        jk_cell u_cell (
            .clk   (clk),
            .reset (reset),
            .j     (j_vec[i]),
            .k     (k_vec[i]),
            .q     (q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            load_err <= 1'b0;
        end else begin
            load_err <= load & load_bad;
        end
    end

`ifdef JK_MOD_COUNTER_GRAY_EN
    // Encoded from target so the Gray value lands on the same edge as q.
    always_ff @(posedge clk) begin
        if (reset) begin
            q_gray <= '0;
        end else begin
            q_gray <= target ^ (target >> 1);
        end
    end
`endif

endmodule

// File: tb/tb_jk_mod_counter.sv
// Scoreboard bench for jk_mod_counter: a reference model predicts each next count,
// combinational outputs are checked before the edge, registered ones after it.
module tb_jk_mod_counter;

    localparam int WIDTH   = 4;
    localparam int MODULUS = 10;

    logic             clk;
    logic             reset;
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] j_vec;
    logic [WIDTH-1:0] k_vec;
    logic             tc;
    logic             load_err;
`ifdef JK_MOD_COUNTER_GRAY_EN
    logic [WIDTH-1:0] q_gray;
`endif

    jk_mod_counter #(.WIDTH(WIDTH), .MODULUS(MODULUS)) dut (
        .clk      (clk),
        .reset    (reset),
        .en       (en),
        .up       (up),
        .load     (load),
        .load_val (load_val),
        .q        (q),
        .j_vec    (j_vec),
        .k_vec    (k_vec),
        .tc       (tc),
        .load_err (load_err)
`ifdef JK_MOD_COUNTER_GRAY_EN
        ,
        .q_gray   (q_gray)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [WIDTH-1:0] q;
        logic             err;
        logic             was_reset;
        logic [WIDTH-1:0] j;
        logic [WIDTH-1:0] k;
        logic [WIDTH-1:0] q_prev;
        string            tag;
    } sb_entry_t;

    sb_entry_t sb_q[$];
    int total = 0;
    int bad   = 0;
    int mq    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive, check combinational outputs, push expectation, pop after edge.
    task automatic cycle(input logic r, input logic e, input logic u, input logic l,
                         input logic [WIDTH-1:0] lv, input string tag);
        int               nxt;
        logic [WIDTH-1:0] cur;
        logic [WIDTH-1:0] nv;
        logic [WIDTH-1:0] ej;
        logic [WIDTH-1:0] ek;
        logic [WIDTH-1:0] qc;
        logic             etc;
        sb_entry_t        ent;
        sb_entry_t        got;

        reset = r; en = e; up = u; load = l; load_val = lv;
        #1;
        if (l)      nxt = (int'(lv) < MODULUS) ? int'(lv) : 0;
        else if (e) nxt = u ? ((mq == MODULUS - 1) ? 0 : mq + 1)
                            : ((mq == 0) ? MODULUS - 1 : mq - 1);
        else        nxt = mq;
        if (r) nxt = 0;

        cur = WIDTH'(mq);
        nv  = WIDTH'(nxt);
        ej  = ~cur & nv;
        ek  = cur & ~nv;
        etc = e & ~l & ((u & (mq == MODULUS - 1)) | (~u & (mq == 0)));

        check({tag, ".q_pre"}, 32'(q), 32'(cur));
        if (!r) begin
            check({tag, ".tc"},    32'(tc),    32'(etc));
            check({tag, ".j_vec"}, 32'(j_vec), 32'(ej));
            check({tag, ".k_vec"}, 32'(k_vec), 32'(ek));
            check({tag, ".no_tog"}, 32'(j_vec & k_vec), 32'(0));
        end

        ent.q         = nv;
        ent.err       = !r && l && (int'(lv) >= MODULUS);
        ent.was_reset = r;
        ent.j         = j_vec;
        ent.k         = k_vec;
        ent.q_prev    = q;
        ent.tag       = tag;
        sb_q.push_back(ent);

        @(posedge clk);
        #2;
        got = sb_q.pop_front();
        check({got.tag, ".q"},        32'(q),        32'(got.q));
        check({got.tag, ".load_err"}, 32'(load_err), 32'(got.err));
`ifdef JK_MOD_COUNTER_GRAY_EN
        check({got.tag, ".q_gray"}, 32'(q_gray), 32'(got.q ^ (got.q >> 1)));
`endif
        if (!got.was_reset) begin
            for (int i = 0; i < WIDTH; i++) begin
                case ({got.j[i], got.k[i]})
                    2'b00:   qc[i] = got.q_prev[i];
                    2'b01:   qc[i] = 1'b0;
                    2'b10:   qc[i] = 1'b1;
                    default: qc[i] = ~got.q_prev[i];
                endcase
            end
            check({got.tag, ".charac"}, 32'(q), 32'(qc));
        end
        mq = int'(got.q);
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; load_val = '0;
        @(posedge clk);
        #2;
        check("reset.q", 32'(q), 32'(0));
        check("reset.load_err", 32'(load_err), 32'(0));
        mq = 0;

        // Up count through the wrap.
        cycle(1, 0, 1, 0, 0, "rst_up");
        for (int n = 0; n < 12; n++) cycle(0, 1, 1, 0, 0, $sformatf("up%0d", n));

        // Down count from reset wraps to MODULUS-1.
        cycle(1, 0, 0, 0, 0, "rst_dn");
        for (int n = 0; n < 4; n++) cycle(0, 1, 0, 0, 0, $sformatf("dn%0d", n));

        // Hold, illegal load, legal load, hold.
        cycle(0, 0, 1, 0, 0, "hold");
        cycle(0, 0, 1, 1, 4'd12, "ld_bad");
        cycle(0, 0, 1, 1, 4'd5,  "ld_ok");
        cycle(0, 0, 1, 0, 0, "hold2");
        cycle(0, 0, 1, 1, 4'd9,  "ld_max");
        cycle(0, 0, 1, 1, 4'd10, "ld_mod");

        // Load 7 then count up to see j=1000/k=0111.
        cycle(0, 0, 1, 1, 4'd7, "ld7");
        cycle(0, 1, 1, 0, 0, "q7_up");

        // Load beats enable; then mid-count reset.
        cycle(0, 0, 1, 1, 4'd4, "ld4");
        cycle(0, 1, 1, 1, 4'd2, "ld_en");
        for (int n = 0; n < 4; n++) cycle(0, 1, 1, 0, 0, $sformatf("to6_%0d", n));
        cycle(1, 1, 1, 0, 0, "mid_rst");
        cycle(0, 1, 1, 0, 0, "resume");
        cycle(0, 1, 0, 0, 0, "dir_chg");

        // Random traffic.
        for (int n = 0; n < 300; n++) begin
            cycle(($urandom_range(0, 39) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
                  ($urandom_range(0, 5) == 0), WIDTH'($urandom_range(0, 15)),
                  $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
